rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Shares the register file's single write-back port between two producers: the execute pipe (A) and the load/memory pipe (M).
//  - Each producer feeds its own small request FIFO.
//  - One queued write per cycle is granted and driven, registered, onto the register file's wr_en/ppp/in_addr/in_data.
//  - A pending-write query lets decode stall on operands whose write-back is still queued.
// PARAMETERS
//  FIFO_DEPTH  2   entries per requester FIFO (power of 2, >=2)
//  ADDR_W      6   register address width
//  DATA_W      64  write data width
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  a_valid    in   1       execute write-back request
//  a_ready    out  1       A FIFO can accept
//  a_addr     in   ADDR_W  destination register
//  a_ppp      in   3       partial-write select
//  a_data     in   DATA_W  write data
//  m_valid    in   1       load write-back request
//  m_ready    out  1       M FIFO can accept
//  m_addr     in   ADDR_W  destination register
//  m_ppp      in   3       partial-write select
//  m_data     in   DATA_W  write data
//  wb_wr_en   out  1       to register file wr_en
//  wb_ppp     out  3       to register file ppp
//  wb_addr    out  ADDR_W  to register file in_addr
//  wb_data    out  DATA_W  to register file in_data
//  q_addr1    in   ADDR_W  decode operand rA
//  q_addr2    in   ADDR_W  decode operand rB
//  q_hit1     out  1       rA has a queued/in-flight write
//  q_hit2     out  1       rB has a queued/in-flight write
//  busy       out  1       any FIFO non-empty or wb_wr_en high
// BEHAVIOUR
//  - Reset: every output is 0 during and after the reset cycle (ready ports included). FIFOs are flushed, the RR pointer selects A.
//    - Reset mid-operation drops all queued writes. No partial write is issued.
//  - Handshake: a transfer occurs when x_valid && x_ready at a posedge.
//    - x_ready = !full, computed from the registered count only, never from the same-cycle pop.
//    - When full, ready stays low even if a pop occurs in the same cycle.
//  - Address 0: accepted (ready honoured) but not enqueued. It never reaches wb_* and never sets a q_hit.
//  - ppp is forwarded unmodified, including the unused codes 101-111.
//  - Arbitration: each cycle, at most one FIFO head is popped.
//    - Winner is registered into wb_* and wb_wr_en=1 the next cycle.
//    - With no winner, wb_wr_en=0 and wb_addr/ppp/data hold their previous values.
//  - Latency: request accepted at edge N -> wb_wr_en high in cycle N+2 if uncontended. Throughput is 1 write per cycle.
//  - Order within a requester is FIFO. There is no ordering between A and M.
//    - Upstream guarantees that no two in-flight writes from different requesters target the same register.
//  - q_hitK (combinational) = 1 when q_addrK != 0 and q_addrK matches any valid entry of either FIFO, or matches wb_addr while wb_wr_en=1.
//    - Same-cycle enqueues are not visible until the next cycle.
//  - Simultaneous push+pop on a non-full FIFO: both happen, count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
// CONFIGURATION
//  RF_WB_RR_EN defined: round-robin arbitration.
//    - On a tie, grant the requester not granted last. The pointer updates only on an actual grant.
//  RF_WB_RR_EN undefined: fixed priority, M always beats A.
//    - A can starve under continuous M traffic. This is accepted for this configuration.
// STRUCTURE
//  rf_pkg (shared include) holds:
//    - PPP_FULL=3'b000, PPP_HI32=3'b001, PPP_LO32=3'b010, PPP_EVENB=3'b011, PPP_ODDB=3'b100
//    - REG_ZERO=0, the default register address/data widths
//  Sub-module rf_wb_fifo (depth/width parameterised, exposes all entries' addr+valid for the q_hit compare) is instantiated twice.
//  The arbiter, output register and hit logic live in the top.
// TESTING
//  - Reset: hold rst 3 cycles with a_valid=m_valid=1 -> all outputs 0, nothing written; first grant only after rst falls.
//  - Single A write addr=5 ppp=000 data=0xDEAD_BEEF_0000_0001 at edge N -> wb_wr_en=1, wb_addr=5 with that data in cycle N+2; busy falls after.
//  - Both FIFOs preloaded with 2 entries:
//    - RR_EN: grants alternate A,M,A,M.
//    - No RR_EN: M,M,A,A.
//    - Either way wb_wr_en stays high 4 consecutive cycles.
//  - Fill A with depth 2 while output idle-blocked by M priority -> a_ready=0; a third a_valid is held, not lost, and later issued in order.
//  - addr=0 request -> a_ready honoured, no wb_wr_en, q_hit1 with q_addr1=0 stays 0.
//  - Queue addr=7 ppp=011 -> q_hit1=1 for q_addr1=7 from the cycle after acceptance through the wb_wr_en cycle, 0 after.
//    - wb_ppp=011 is passed through.
//  - Assert rst while 3 entries are queued -> no wb_wr_en after reset; q_hit*=0; busy=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the register-file write-back path: partial-write codes,
// the reserved zero register and default address/data widths.
package rf_pkg;

  localparam logic [2:0] PPP_FULL  = 3'b000;
  localparam logic [2:0] PPP_HI32  = 3'b001;
  localparam logic [2:0] PPP_LO32  = 3'b010;
  localparam logic [2:0] PPP_EVENB = 3'b011;
  localparam logic [2:0] PPP_ODDB  = 3'b100;

  localparam int REG_ZERO   = 0;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 64;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_M = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small circular request FIFO for one write-back producer. Every entry's address
// and occupancy is exposed so the top can answer pending-write queries.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PAY_W  = 3 + DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [PAY_W-1:0]  push_pay,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [PAY_W-1:0]  head_pay,
  output logic [ADDR_W-1:0] entry_addr [DEPTH],
  output logic [DEPTH-1:0]  entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PAY_W-1:0]  mem_pay  [DEPTH];
  logic [PW-1:0]     offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_pay[wr_ptr]  <= push_pay;
    end
  end

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_addr  = mem_addr[rd_ptr];
  assign head_pay   = mem_pay[rd_ptr];
  assign entry_addr = mem_addr;

  always_comb begin
    entry_valid = '0;
    offset      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the execute (A) and load (M) pipes.
// Define RF_WB_RR_EN for round-robin; otherwise M has fixed priority over A.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [2:0]        a_ppp,
  input  logic [DATA_W-1:0] a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [2:0]        m_ppp,
  input  logic [DATA_W-1:0] m_data,
  output logic              wb_wr_en,
  output logic [2:0]        wb_ppp,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] q_addr1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_hit1,
  output logic              q_hit2,
  output logic              busy
);

  localparam int PAY_W = 3 + DATA_W;

  logic              a_full, a_empty, a_push, a_pop;
  logic              m_full, m_empty, m_push, m_pop;
  logic [ADDR_W-1:0] a_head_addr, m_head_addr;
  logic [PAY_W-1:0]  a_head_pay, m_head_pay;
  logic [ADDR_W-1:0] a_entry_addr [FIFO_DEPTH];
  logic [ADDR_W-1:0] m_entry_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] a_entry_valid, m_entry_valid;
  logic              hit1, hit2;

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign a_ready = !rst && !a_full;
  assign m_ready = !rst && !m_full;
  assign a_push  = a_valid && a_ready && (a_addr != ADDR_W'(REG_ZERO));
  assign m_push  = m_valid && m_ready && (m_addr != ADDR_W'(REG_ZERO));

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .PAY_W(PAY_W)) u_fifo_a (
    .clk(clk), .rst(rst), .push(a_push), .push_addr(a_addr),
    .push_pay({a_ppp, a_data}), .pop(a_pop), .full(a_full), .empty(a_empty),
    .head_addr(a_head_addr), .head_pay(a_head_pay),
    .entry_addr(a_entry_addr), .entry_valid(a_entry_valid)
  );

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W), .PAY_W(PAY_W)) u_fifo_m (
    .clk(clk), .rst(rst), .push(m_push), .push_addr(m_addr),
    .push_pay({m_ppp, m_data}), .pop(m_pop), .full(m_full), .empty(m_empty),
    .head_addr(m_head_addr), .head_pay(m_head_pay),
    .entry_addr(m_entry_addr), .entry_valid(m_entry_valid)
  );

`ifdef RF_WB_RR_EN
  req_e rr_pref;

  always_ff @(posedge clk) begin
    if (rst)        rr_pref <= REQ_A;
    else if (a_pop) rr_pref <= REQ_M;
    else if (m_pop) rr_pref <= REQ_A;
  end

  always_comb begin
    a_pop = 1'b0;
    m_pop = 1'b0;
    if (!a_empty && !m_empty) begin
      if (rr_pref == REQ_A) a_pop = 1'b1;
      else                  m_pop = 1'b1;
    end else if (!a_empty) begin
      a_pop = 1'b1;
    end else if (!m_empty) begin
      m_pop = 1'b1;
    end
  end
`else
  always_comb begin
    a_pop = 1'b0;
    m_pop = 1'b0;
    if (!m_empty)      m_pop = 1'b1;
    else if (!a_empty) a_pop = 1'b1;
  end
`endif

  // Address/ppp/data hold their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wr_en <= 1'b0;
      wb_ppp   <= '0;
      wb_addr  <= '0;
      wb_data  <= '0;
    end else begin
      wb_wr_en <= a_pop || m_pop;
      if (m_pop) begin
        wb_addr           <= m_head_addr;
        {wb_ppp, wb_data} <= m_head_pay;
      end else if (a_pop) begin
        wb_addr           <= a_head_addr;
        {wb_ppp, wb_data} <= a_head_pay;
      end
    end
  end

  always_comb begin
    hit1 = wb_wr_en && (wb_addr == q_addr1);
    hit2 = wb_wr_en && (wb_addr == q_addr2);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (a_entry_valid[i] && (a_entry_addr[i] == q_addr1)) hit1 = 1'b1;
      if (m_entry_valid[i] && (m_entry_addr[i] == q_addr1)) hit1 = 1'b1;
      if (a_entry_valid[i] && (a_entry_addr[i] == q_addr2)) hit2 = 1'b1;
      if (m_entry_valid[i] && (m_entry_addr[i] == q_addr2)) hit2 = 1'b1;
    end
  end

  assign q_hit1 = !rst && hit1 && (q_addr1 != ADDR_W'(REG_ZERO));
  assign q_hit2 = !rst && hit2 && (q_addr2 != ADDR_W'(REG_ZERO));
  assign busy   = !rst && (!a_empty || !m_empty || wb_wr_en);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then random traffic,
// all compared against a queue-based model of the write-back rules.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    logic [5:0]  addr;
    logic [2:0]  ppp;
    logic [63:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, m_valid;
  logic        a_ready, m_ready;
  logic [5:0]  a_addr, m_addr, q_addr1, q_addr2, wb_addr;
  logic [2:0]  a_ppp, m_ppp, wb_ppp;
  logic [63:0] a_data, m_data, wb_data;
  logic        wb_wr_en, q_hit1, q_hit2, busy;

  int checks = 0;
  int errors = 0;

  wr_t         qa[$];
  wr_t         qm[$];
  bit          pref_a = 1'b1;
  bit          checking = 1'b0;
  bit          acc_a, acc_m;
  logic        exp_en;
  logic [5:0]  exp_addr;
  logic [2:0]  exp_ppp;
  logic [63:0] exp_data;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(6), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_ppp(a_ppp), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_ppp(m_ppp), .m_data(m_data),
    .wb_wr_en(wb_wr_en), .wb_ppp(wb_ppp), .wb_addr(wb_addr), .wb_data(wb_data),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pending(input logic [5:0] a);
    if (a == 6'd0) return 1'b0;
    foreach (qa[i]) if (qa[i].addr == a) return 1'b1;
    foreach (qm[i]) if (qm[i].addr == a) return 1'b1;
    return exp_en && (exp_addr == a);
  endfunction

  task automatic checkOutput();
    if (!checking) return;
    chk("a_ready",  a_ready,  !rst && (qa.size() < DEPTH));
    chk("m_ready",  m_ready,  !rst && (qm.size() < DEPTH));
    chk("wb_wr_en", wb_wr_en, exp_en);
    chk("wb_addr",  wb_addr,  exp_addr);
    chk("wb_ppp",   wb_ppp,   exp_ppp);
    chk("wb_data",  wb_data,  exp_data);
    chk("q_hit1",   q_hit1,   !rst && pending(q_addr1));
    chk("q_hit2",   q_hit2,   !rst && pending(q_addr2));
    chk("busy",     busy,     !rst && (qa.size() > 0 || qm.size() > 0 || exp_en));
  endtask

  // One clock edge of the reference behaviour, using the inputs held across it.
  task automatic modelUpdate();
    bit  take_m;
    wr_t w;
    if (rst) begin
      qa.delete();
      qm.delete();
      {exp_en, exp_addr, exp_ppp, exp_data} = '0;
      pref_a   = 1'b1;
      acc_a    = 1'b0;
      acc_m    = 1'b0;
      checking = 1'b1;
      return;
    end
    acc_a = a_valid && (qa.size() < DEPTH);
    acc_m = m_valid && (qm.size() < DEPTH);
`ifdef RF_WB_RR_EN
    take_m = (qm.size() > 0) && ((qa.size() == 0) || !pref_a);
`else
    take_m = (qm.size() > 0);
`endif
    exp_en = 1'b0;
    if (take_m) begin
      w = qm.pop_front();
      pref_a = 1'b1;
      exp_en = 1'b1;
    end else if (qa.size() > 0) begin
      w = qa.pop_front();
      pref_a = 1'b0;
      exp_en = 1'b1;
    end
    if (exp_en) begin
      exp_addr = w.addr;
      exp_ppp  = w.ppp;
      exp_data = w.data;
    end
    if (acc_a && a_addr != 6'd0) qa.push_back('{a_addr, a_ppp, a_data});
    if (acc_m && m_addr != 6'd0) qm.push_back('{m_addr, m_ppp, m_data});
  endtask

  task automatic applyStimulus(input bit r,
                               input bit av, input logic [5:0] aa, input logic [2:0] ap, input logic [63:0] ad,
                               input bit mv, input logic [5:0] ma, input logic [2:0] mp, input logic [63:0] md,
                               input logic [5:0] q1, input logic [5:0] q2);
    rst = r;
    a_valid = av; a_addr = aa; a_ppp = ap; a_data = ad;
    m_valid = mv; m_addr = ma; m_ppp = mp; m_data = md;
    q_addr1 = q1; q_addr2 = q2;
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [5:0] q1, input logic [5:0] q2);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  initial begin
    logic [5:0] held [3];
    int         hi;
    held[0] = 6'd3; held[1] = 6'd4; held[2] = 6'd11;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 6'd1, 3'd0, 64'h11, 1, 6'd2, 3'd0, 64'h22, 6'd1, 6'd2);

    applyStimulus(0, 1, 6'd5, 3'b000, 64'hDEAD_BEEF_0000_0001, 0, 0, 0, 0, 6'd5, 6'd0);
    idle(4, 6'd5, 6'd1);

    applyStimulus(0, 1, 6'd1, 3'd1, 64'hA1, 1, 6'd9, 3'd2, 64'hB1, 6'd1, 6'd9);
    applyStimulus(0, 1, 6'd2, 3'd3, 64'hA2, 1, 6'd10, 3'd4, 64'hB2, 6'd2, 6'd10);
    idle(6, 6'd2, 6'd10);

    hi = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, hi < 3, (hi < 3) ? held[hi] : 6'd0, 3'd2, 64'hC0 + 64'(hi),
                    1, 6'd20 + 6'(i), 3'd0, 64'hE0 + 64'(i), 6'd3, 6'd11);
      if (acc_a && hi < 3) hi++;
    end
    idle(10, 6'd4, 6'd11);

    applyStimulus(0, 1, 6'd0, 3'd0, 64'h55, 0, 0, 0, 0, 6'd0, 6'd0);
    idle(3, 6'd0, 6'd0);

    applyStimulus(0, 1, 6'd7, 3'b011, 64'h77, 0, 0, 0, 0, 6'd7, 6'd7);
    idle(4, 6'd7, 6'd0);

    applyStimulus(0, 1, 6'd12, 3'd5, 64'h12, 1, 6'd14, 3'd6, 64'h14, 6'd12, 6'd14);
    applyStimulus(0, 1, 6'd13, 3'd7, 64'h13, 1, 6'd15, 3'd7, 64'h15, 6'd13, 6'd15);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'd13, 6'd15);
    idle(3, 6'd13, 6'd15);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(99) == 0,
                    $urandom_range(9) < 7, 6'($urandom_range(7)), 3'($urandom), {$urandom, $urandom},
                    $urandom_range(9) < 7, 6'($urandom_range(7)), 3'($urandom), {$urandom, $urandom},
                    6'($urandom_range(7)), 6'($urandom_range(7)));
    end
    idle(6, 6'd1, 6'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
